// File: rtl/fc_layer_pkg.sv
// Shared FSM encoding and width helper for the fully-connected classifier stage.
package fc_layer_pkg;

    localparam logic [1:0] ST_LOAD    = 2'd0;
    localparam logic [1:0] ST_COMPUTE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    // Ceiling log2, never below 1 so a single-entry range still gets a bit.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/fc_mac_unit.sv
// Serial signed MAC with bias add, arithmetic shift and output saturation.
module fc_mac_unit
    import fc_layer_pkg::*;
#(
    parameter int I_BW       = 16,
    parameter int W_BW       = 8,
    parameter int B_BW       = 16,
    parameter int ACC_BW     = 32,
    parameter int O_BW       = 16,
    parameter int FRAC_SHIFT = 8
) (
    input  logic                   clk,
    input  logic                   global_rst_n,
    input  logic                   clr,
    input  logic                   mac_en,
    input  logic                   bias_en,
    input  logic signed [I_BW-1:0] fmap,
    input  logic signed [W_BW-1:0] weight,
    input  logic signed [B_BW-1:0] bias,
    output logic signed [O_BW-1:0] score
);

    localparam int P_BW = I_BW + W_BW;
    localparam logic signed [ACC_BW-1:0] SAT_MAX = {{(ACC_BW-O_BW+1){1'b0}}, {(O_BW-1){1'b1}}};
    localparam logic signed [ACC_BW-1:0] SAT_MIN = {{(ACC_BW-O_BW+1){1'b1}}, {(O_BW-1){1'b0}}};

    function automatic logic signed [O_BW-1:0] saturate(input logic signed [ACC_BW-1:0] value);
        if (value > SAT_MAX) return {1'b0, {(O_BW-1){1'b1}}};
        if (value < SAT_MIN) return {1'b1, {(O_BW-1){1'b0}}};
        return value[O_BW-1:0];
    endfunction

    logic signed [P_BW-1:0]   product;
    logic signed [ACC_BW-1:0] acc_p0;
    logic signed [ACC_BW-1:0] bias_ext;
    logic signed [ACC_BW-1:0] biased;
    logic signed [ACC_BW-1:0] shifted;

    assign product  = P_BW'(fmap) * P_BW'(weight);
    assign bias_ext = ACC_BW'(bias);
    assign biased   = acc_p0 + bias_ext;
    assign shifted  = biased >>> FRAC_SHIFT;
    assign score    = saturate(shifted);

    // Accumulator restarts after every bias cycle so each neuron begins from zero.
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            acc_p0 <= '0;
        end else if (clr || bias_en) begin
            acc_p0 <= '0;
        end else if (mac_en) begin
            acc_p0 <= acc_p0 + ACC_BW'(product);
        end
    end

endmodule

// File: rtl/fc_layer.sv
// Fully-connected classifier: buffers one pooled feature map, then scores N_OUT neurons serially.
module fc_layer
    import fc_layer_pkg::*;
#(
    parameter int I_BW       = 16,
    parameter int W_BW       = 8,
    parameter int B_BW       = 16,
    parameter int ACC_BW     = 32,
    parameter int O_BW       = 16,
    parameter int N_IN       = 192,
    parameter int N_OUT      = 10,
    parameter int FRAC_SHIFT = 8
) (
    input  logic                          clk,
    input  logic                          global_rst_n,
    input  logic                          user_reset,
    input  logic signed [I_BW-1:0]        i_fmap,
    input  logic                          i_valid,
    input  logic                          i_all_end,
    input  logic [N_OUT*N_IN*W_BW-1:0]    i_weight,
    input  logic [N_OUT*B_BW-1:0]         i_bias,
    output logic signed [O_BW-1:0]        o_result,
    output logic                          o_valid,
    output logic [3:0]                    o_idx,
    output logic                          o_done,
    output logic [3:0]                    o_argmax,
    output logic                          o_err
);

    localparam int PTR_W = clog2(N_IN);
    localparam int J_W   = clog2(N_IN + 1);
    localparam int N_W   = clog2(N_OUT);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_IN - 1);
    localparam logic [J_W-1:0]   J_BIAS   = J_W'(N_IN);
    localparam logic [N_W-1:0]   N_LAST   = N_W'(N_OUT - 1);

    logic [1:0]             state;
    logic [PTR_W-1:0]       wr_ptr;
    logic [J_W-1:0]         j;
    logic [N_W-1:0]         n;
    logic                   reported;
    logic signed [O_BW-1:0] max_score;
    logic [N_W-1:0]         max_idx;
    logic signed [I_BW-1:0] fbuf [N_IN];

    logic                   load_wr;
    logic                   load_last;
    logic                   mac_cycle;
    logic                   bias_cycle;
    logic [PTR_W-1:0]       rd_idx;
    logic signed [W_BW-1:0] w_sel;
    logic signed [B_BW-1:0] b_sel;
    logic signed [O_BW-1:0] score;

    assign load_wr    = (state == ST_LOAD) && i_valid;
    assign load_last  = load_wr && (wr_ptr == PTR_LAST);
    assign bias_cycle = (state == ST_COMPUTE) && (j == J_BIAS);
    assign mac_cycle  = (state == ST_COMPUTE) && (j != J_BIAS);
    assign rd_idx     = j[PTR_W-1:0];
    assign w_sel      = i_weight[(int'(n) * N_IN + int'(rd_idx)) * W_BW +: W_BW];
    assign b_sel      = i_bias[int'(n) * B_BW +: B_BW];

    always_ff @(posedge clk) begin
        if (load_wr) fbuf[wr_ptr] <= i_fmap;
    end

    fc_mac_unit #(
        .I_BW       (I_BW),
        .W_BW       (W_BW),
        .B_BW       (B_BW),
        .ACC_BW     (ACC_BW),
        .O_BW       (O_BW),
        .FRAC_SHIFT (FRAC_SHIFT)
    ) u_mac (
        .clk          (clk),
        .global_rst_n (global_rst_n),
        .clr          (user_reset),
        .mac_en       (mac_cycle),
        .bias_en      (bias_cycle),
        .fmap         (fbuf[rd_idx]),
        .weight       (w_sel),
        .bias         (b_sel),
        .score        (score)
    );

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            state     <= ST_LOAD;
            wr_ptr    <= '0;
            j         <= '0;
            n         <= '0;
            reported  <= 1'b0;
            max_score <= '0;
            max_idx   <= '0;
            o_result  <= '0;
            o_valid   <= 1'b0;
            o_idx     <= '0;
            o_done    <= 1'b0;
            o_argmax  <= '0;
            o_err     <= 1'b0;
        end else if (user_reset) begin
            state     <= ST_LOAD;
            wr_ptr    <= '0;
            j         <= '0;
            n         <= '0;
            reported  <= 1'b0;
            max_score <= '0;
            max_idx   <= '0;
            o_result  <= '0;
            o_valid   <= 1'b0;
            o_idx     <= '0;
            o_done    <= 1'b0;
            o_argmax  <= '0;
            o_err     <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            o_done  <= 1'b0;
            case (state)
                ST_LOAD: begin
                    // An end marker is only legitimate together with the final sample.
                    if (i_all_end && !load_last) o_err <= 1'b1;
                    if (load_wr) wr_ptr <= load_last ? '0 : wr_ptr + 1'b1;
                    if (load_last) begin
                        state <= ST_COMPUTE;
                        j     <= '0;
                        n     <= '0;
                    end
                end
                ST_COMPUTE: begin
                    if (bias_cycle) begin
                        o_result <= score;
                        o_valid  <= 1'b1;
                        o_idx    <= 4'(n);
                        j        <= '0;
                        n        <= n + 1'b1;
                        // Strict compare keeps the lowest index on ties.
                        if (n == '0 || score > max_score) begin
                            max_score <= score;
                            max_idx   <= n;
                        end
                        if (n == N_LAST) state <= ST_DONE;
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!reported) begin
                        o_done   <= 1'b1;
                        o_argmax <= 4'(max_idx);
                        reported <= 1'b1;
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_layer.sv
// Scoreboard bench for fc_layer: random images against a plain-arithmetic reference model.
module tb_fc_layer;

    localparam int N_IN  = 192;
    localparam int N_OUT = 10;
    localparam int S_IN  = 4;
    localparam int S_OUT = 3;

    typedef struct { int idx; int res; int due; } vexp_t;
    typedef struct { int arg; int due; } dexp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                        global_rst_n;
    logic                        user_reset;
    logic signed [15:0]          i_fmap;
    logic                        i_valid;
    logic                        i_all_end;
    logic [N_OUT*N_IN*8-1:0]     i_weight;
    logic [N_OUT*16-1:0]         i_bias;
    logic signed [15:0]          o_result;
    logic                        o_valid;
    logic [3:0]                  o_idx;
    logic                        o_done;
    logic [3:0]                  o_argmax;
    logic                        o_err;

    logic                        s_user_reset;
    logic signed [15:0]          s_fmap;
    logic                        s_valid;
    logic                        s_all_end;
    logic [S_OUT*S_IN*8-1:0]     s_weight;
    logic [S_OUT*16-1:0]         s_bias;
    logic signed [15:0]          s_result;
    logic                        s_o_valid;
    logic [3:0]                  s_idx;
    logic                        s_done;
    logic [3:0]                  s_argmax;
    logic                        s_err;

    fc_layer dut (
        .clk(clk), .global_rst_n(global_rst_n), .user_reset(user_reset),
        .i_fmap(i_fmap), .i_valid(i_valid), .i_all_end(i_all_end),
        .i_weight(i_weight), .i_bias(i_bias),
        .o_result(o_result), .o_valid(o_valid), .o_idx(o_idx),
        .o_done(o_done), .o_argmax(o_argmax), .o_err(o_err)
    );

    fc_layer #(.N_IN(S_IN), .N_OUT(S_OUT), .FRAC_SHIFT(0)) dut_s (
        .clk(clk), .global_rst_n(global_rst_n), .user_reset(s_user_reset),
        .i_fmap(s_fmap), .i_valid(s_valid), .i_all_end(s_all_end),
        .i_weight(s_weight), .i_bias(s_bias),
        .o_result(s_result), .o_valid(s_o_valid), .o_idx(s_idx),
        .o_done(s_done), .o_argmax(s_argmax), .o_err(s_err)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;
    int last_arg = 0;
    int feat [N_IN];
    int wt   [N_OUT][N_IN];
    int bs   [N_OUT];
    vexp_t vq[$];
    dexp_t dq[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every presented output pops one expectation.
    always @(negedge clk) begin : monitor
        vexp_t e;
        dexp_t d;
        if (global_rst_n) begin
            if (o_valid) begin
                if (vq.size() == 0) check("spurious_o_valid", longint'(o_valid), 0);
                else begin
                    e = vq.pop_front();
                    check("o_idx", longint'(o_idx), e.idx);
                    check("o_result", longint'(o_result), e.res);
                    check("o_valid_cycle", longint'(cyc), e.due);
                end
            end
            if (o_done) begin
                done_cnt++;
                check("valid_with_done", longint'(o_valid), 0);
                if (dq.size() == 0) check("spurious_o_done", longint'(o_done), 0);
                else begin
                    d = dq.pop_front();
                    check("o_argmax", longint'(o_argmax), d.arg);
                    check("o_done_cycle", longint'(cyc), d.due);
                end
            end
        end
    end

    task automatic model_push(input int tl, input int nmax, input bit with_done);
        longint s;
        longint best;
        int best_n;
        vexp_t e;
        dexp_t d;
        best = 0;
        best_n = 0;
        for (int nn = 0; nn < N_OUT; nn++) begin
            s = bs[nn];
            for (int k = 0; k < N_IN; k++) s += longint'(feat[k]) * longint'(wt[nn][k]);
            s = s >>> 8;
            if (s > 32767) s = 32767;
            else if (s < -32768) s = -32768;
            if (nn < nmax) begin
                e.idx = nn;
                e.res = int'(s);
                e.due = tl + (nn + 1) * (N_IN + 1);
                vq.push_back(e);
            end
            if (nn == 0 || s > best) begin
                best = s;
                best_n = nn;
            end
        end
        last_arg = best_n;
        if (with_done) begin
            d.arg = best_n;
            d.due = tl + N_OUT * (N_IN + 1) + 1;
            dq.push_back(d);
        end
    endtask

    task automatic pack_params();
        for (int nn = 0; nn < N_OUT; nn++) begin
            for (int k = 0; k < N_IN; k++) i_weight[(nn*N_IN+k)*8 +: 8] = 8'(wt[nn][k]);
            i_bias[nn*16 +: 16] = 16'(bs[nn]);
        end
    endtask

    task automatic rand_image(input int fmag);
        for (int k = 0; k < N_IN; k++) feat[k] = int'($urandom_range(0, 2*fmag)) - fmag;
        for (int nn = 0; nn < N_OUT; nn++) begin
            for (int k = 0; k < N_IN; k++) wt[nn][k] = int'($urandom_range(0, 255)) - 128;
            bs[nn] = int'($urandom_range(0, 65535)) - 32768;
        end
        pack_params();
    endtask

    // Returns the clock-edge number at which the final sample is captured.
    task automatic feed(input int gap_max, input int end_at, input bit end_with_last, output int tl);
        for (int k = 0; k < N_IN; k++) begin
            int g;
            g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            if (k == end_at && g < 1) g = 1;
            for (int q = 0; q < g; q++) begin
                @(negedge clk);
                i_valid   = 1'b0;
                i_fmap    = 16'($urandom);
                i_all_end = (k == end_at) && (q == 0);
            end
            @(negedge clk);
            i_valid   = 1'b1;
            i_fmap    = 16'(feat[k]);
            i_all_end = end_with_last && (k == N_IN - 1);
        end
        tl = cyc + 1;
        @(negedge clk);
        i_valid   = 1'b0;
        i_all_end = 1'b0;
    endtask

    task automatic wait_done(input bit toggle);
        int start;
        int lim;
        start = done_cnt;
        lim = 0;
        while (done_cnt == start && lim < 3000) begin
            @(negedge clk);
            lim++;
            if (toggle) begin
                i_valid   = 1'($urandom);
                i_all_end = 1'($urandom);
                i_fmap    = 16'($urandom);
            end
        end
        i_valid   = 1'b0;
        i_all_end = 1'b0;
        check("o_done_before_timeout", longint'(done_cnt != start), 1);
        repeat (6) begin
            @(negedge clk);
            i_valid = 1'($urandom);
        end
        i_valid = 1'b0;
        check("o_argmax_hold", longint'(o_argmax), last_arg);
    endtask

    task automatic soft_reset();
        @(negedge clk);
        user_reset = 1'b1;
        @(negedge clk);
        user_reset = 1'b0;
        check("rst_o_valid", longint'(o_valid), 0);
        check("rst_o_done", longint'(o_done), 0);
        check("rst_o_err", longint'(o_err), 0);
        check("rst_o_result", longint'(o_result), 0);
        check("rst_o_argmax", longint'(o_argmax), 0);
    endtask

    task automatic full_pass(input int gap_max, input bit toggle, input bit end_with_last);
        int tl;
        feed(gap_max, -1, end_with_last, tl);
        model_push(tl, N_OUT, 1'b1);
        wait_done(toggle);
        check("o_err_clean_pass", longint'(o_err), 0);
    endtask

    task automatic small_run(input bit tie_case);
        int er [S_OUT];
        er = tie_case ? '{10, 10, -10} : '{10, 2, -10};
        for (int k = 0; k < S_IN; k++) begin
            s_weight[(0*S_IN+k)*8 +: 8] = 8'sd1;
            s_weight[(1*S_IN+k)*8 +: 8] = tie_case ? 8'sd1 : ((k == 0) ? 8'sd2 : 8'sd0);
            s_weight[(2*S_IN+k)*8 +: 8] = -8'sd1;
        end
        s_bias = '0;
        @(negedge clk);
        s_user_reset = 1'b1;
        @(negedge clk);
        s_user_reset = 1'b0;
        for (int k = 0; k < S_IN; k++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_fmap  = 16'(k + 1);
        end
        @(negedge clk);
        s_valid = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            check("small_o_valid", longint'(s_o_valid), longint'(c % 5 == 0 && c <= 15));
            check("small_o_done", longint'(s_done), longint'(c == 16));
            if (c % 5 == 0 && c <= 15) begin
                check("small_o_idx", longint'(s_idx), c / 5 - 1);
                check("small_o_result", longint'(s_result), er[c/5-1]);
            end
        end
        check("small_o_argmax", longint'(s_argmax), 0);
    endtask

    initial begin
        int tl;
        global_rst_n = 1'b0;
        user_reset   = 1'b0;
        i_valid      = 1'b0;
        i_all_end    = 1'b0;
        i_fmap       = '0;
        i_weight     = '0;
        i_bias       = '0;
        s_user_reset = 1'b0;
        s_valid      = 1'b0;
        s_all_end    = 1'b0;
        s_fmap       = '0;
        s_weight     = '0;
        s_bias       = '0;
        repeat (3) @(negedge clk);
        check("por_o_valid", longint'(o_valid), 0);
        check("por_o_done", longint'(o_done), 0);
        check("por_o_err", longint'(o_err), 0);
        check("por_o_result", longint'(o_result), 0);
        check("por_o_idx", longint'(o_idx), 0);
        check("por_o_argmax", longint'(o_argmax), 0);
        global_rst_n = 1'b1;

        small_run(1'b0);
        small_run(1'b1);

        // Moderate-range random image; end marker arrives with the final sample.
        rand_image(1000);
        full_pass(0, 1'b0, 1'b1);
        soft_reset();

        // Positive saturation on every neuron, all tied.
        for (int k = 0; k < N_IN; k++) feat[k] = 32767;
        for (int nn = 0; nn < N_OUT; nn++) begin
            bs[nn] = 0;
            for (int k = 0; k < N_IN; k++) wt[nn][k] = 127;
        end
        pack_params();
        full_pass(0, 1'b0, 1'b0);
        soft_reset();

        // Alternating negative/positive saturation with random biases.
        for (int nn = 0; nn < N_OUT; nn++) begin
            bs[nn] = int'($urandom_range(0, 65535)) - 32768;
            for (int k = 0; k < N_IN; k++) wt[nn][k] = (nn % 2 == 0) ? -128 : 127;
        end
        pack_params();
        full_pass(0, 1'b0, 1'b0);
        soft_reset();

        // Early end marker after 100 samples.
        rand_image(4000);
        feed(0, 100, 1'b0, tl);
        check("o_err_after_early_end", longint'(o_err), 1);
        model_push(tl, N_OUT, 1'b1);
        wait_done(1'b0);
        check("o_err_sticky", longint'(o_err), 1);
        soft_reset();

        // Soft reset during neuron 3 aborts the pass.
        rand_image(2000);
        feed(0, -1, 1'b0, tl);
        model_push(tl, 3, 1'b0);
        repeat (3 * (N_IN + 1) + 60) @(negedge clk);
        user_reset = 1'b1;
        @(negedge clk);
        user_reset = 1'b0;
        check("abort_o_valid", longint'(o_valid), 0);
        check("abort_o_done", longint'(o_done), 0);
        check("abort_o_err", longint'(o_err), 0);
        check("abort_o_result", longint'(o_result), 0);
        repeat (2 * (N_IN + 1)) @(negedge clk);
        check("abort_pending_valid", longint'(vq.size()), 0);
        check("abort_pending_done", longint'(dq.size()), 0);
        rand_image(3000);
        full_pass(0, 1'b0, 1'b0);
        soft_reset();

        // Same image gap-free, then with gaps and input noise during COMPUTE.
        for (int r = 0; r < 2; r++) begin
            rand_image((r == 0) ? 32767 : 300);
            full_pass(0, 1'b0, 1'b0);
            soft_reset();
            full_pass(5, 1'b1, 1'b0);
            soft_reset();
        end

        check("leftover_valid_expectations", longint'(vq.size()), 0);
        check("leftover_done_expectations", longint'(dq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fc_layer.md
Name: fc_layer

Overview:
- Fully-connected classifier stage directly downstream of the second convolution layer.
- Captures the 192-value pooled feature stream (12 ch x 4x4) into an internal buffer.
- Runs one serial MAC per cycle per output neuron and emits 10 saturated scores plus the argmax class index.
- Control is a single FSM; only one image is in flight at a time.

Parameters:
- I_BW, 16, signed feature width (matches conv2 output)
- W_BW, 8, signed weight width
- B_BW, 16, signed bias width
- ACC_BW, 32, signed accumulator width
- O_BW, 16, signed output score width
- N_IN, 192, features per image
- N_OUT, 10, output neurons
- FRAC_SHIFT, 8, arithmetic right shift applied before output saturation

Ports:
- clk  in  1  clock
- global_rst_n  in  1  reset, asynchronous, active-low
- user_reset  in  1  synchronous soft reset, same effect as global_rst_n
- i_fmap  in  I_BW  signed feature sample
- i_valid  in  1  i_fmap valid (conv2 pooled-output enable)
- i_all_end  in  1  conv2 all-channel end indication
- i_weight  in  N_OUT*N_IN*W_BW  weight w[n][j] at bits [(n*N_IN+j)*W_BW +: W_BW]
- i_bias  in  N_OUT*B_BW  bias b[n] at bits [n*B_BW +: B_BW]
- o_result  out  O_BW  signed saturated score
- o_valid  out  1  one-cycle strobe, o_result/o_idx valid
- o_idx  out  4  neuron index of o_result
- o_done  out  1  one-cycle strobe after the last neuron
- o_argmax  out  4  winning class; valid from o_done until reset
- o_err  out  1  sticky early-end error

Behaviour:
- Reset (either source): state LOAD; write pointer, neuron counter and input counter = 0; accumulator = 0; all outputs = 0; feature buffer contents don't-care.
- LOAD
  - Each cycle with i_valid=1 writes i_fmap to buf[wr_ptr] and increments wr_ptr.
  - The cycle that writes index N_IN-1 moves to COMPUTE next cycle, with wr_ptr=0, n=0, j=0, acc=0.
  - i_all_end=1 in LOAD while the sample count (including a same-cycle valid) is < N_IN sets o_err=1 (sticky); the FSM stays in LOAD.
  - i_all_end is ignored in all other cases.
- COMPUTE
  - i_valid is ignored and no buffer write occurs.
  - MAC cycle (j = 0..N_IN-1): acc <= acc + sext(buf[j]) * sext(w[n][j]), full-precision product sign-extended to ACC_BW.
  - Cycle after j = N_IN-1 (bias cycle):
    - s = acc + sext(b[n]).
    - o_result <= sat(s >>> FRAC_SHIFT), clamped to [-2^(O_BW-1), 2^(O_BW-1)-1].
    - o_valid <= 1, o_idx <= n.
    - acc <= 0, j <= 0, n <= n+1.
  - Each neuron takes N_IN+1 cycles. For neuron n, o_valid is high on cycle (n+1)*(N_IN+1) counting from the first COMPUTE cycle as cycle 1. The full pass is N_OUT*(N_IN+1) cycles.
  - Argmax:
    - Compare the saturated score against a running max.
    - n=0 initialises the max.
    - A later neuron replaces the max only if strictly greater, so ties keep the lowest index.
  - After the bias cycle of n = N_OUT-1, move to DONE.
- DONE
  - On entry: o_done=1 for one cycle; o_argmax updated that same cycle.
  - o_argmax holds until reset.
  - Incoming i_valid is ignored.
  - Leaves only via user_reset or global_rst_n, which return the FSM to LOAD for the next image.
- o_valid and o_done are never high in the same cycle.
- o_done rises one cycle after the last o_valid.
- o_result holds its last value when o_valid=0.
- Reset mid-COMPUTE aborts the pass: no further o_valid or o_done, and all outputs clear on the next edge (immediately for global_rst_n).
- Overflow: ACC_BW is sized so that N_IN*max|x*w| + max|b| fits, so no wrap is permitted. Saturation is applied only at the output.

Decomposition:
- Shared package/header:
  - FSM state encoding (LOAD, COMPUTE, DONE)
  - the clog2 function already used in the codebase
  - derived widths: clog2(N_IN) for pointers, clog2(N_OUT) for the index
- One natural sub-module: fc_mac_unit (signed multiply, accumulate, bias add, shift, saturate).
- FSM, counters, feature buffer and argmax stay in fc_layer.

Test Plan:
- N_IN=4, N_OUT=3, FRAC_SHIFT=0; features {1,2,3,4}; w0={1,1,1,1}, w1={2,0,0,0}, w2={-1,-1,-1,-1}; biases 0 -> o_valid at cycles 5,10,15 with (idx,result) = (0,10), (1,2), (2,-10); o_done at cycle 16; o_argmax=0.
- Same features; w1={1,1,1,1}, so neurons 0 and 1 both score 10 -> o_argmax=0 (tie keeps lowest index).
- Default params; all features 32767, all weights 127, bias 0, FRAC_SHIFT=8 -> o_result=32767 (saturated) for every neuron.
- i_all_end pulsed after 100 valid samples -> o_err=1; the FSM stays in LOAD and accepts the remaining 92 samples, then computes normally.
- user_reset asserted mid-COMPUTE (neuron 3) -> no further o_valid, o_done=0, o_err=0, and a fresh image then produces a correct full pass.
- i_valid bursts with random gaps of 0-5 cycles during LOAD, and i_valid toggling during COMPUTE -> results identical to the gap-free run; COMPUTE-phase samples are ignored.
